imem_loader: RTL and testbench

- Write-side companion to the instruction memory.
- Accepts a byte stream of a Y86-64 program over a valid/ready handshake.
- Emits one registered byte-write per accepted byte, at consecutive addresses, on the instruction memory write port.
- Holds the CPU while a load is in progress and reports completion, byte count, XOR checksum and out-of-range errors.

---
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader.
// Accepts a program byte stream over a valid/ready handshake and writes each
// accepted byte to consecutive instruction memory addresses. It holds the CPU
// while a load is in progress and reports completion, byte count, checksum
// and out-of-range errors.
module imem_loader #(
   parameter int MEM_SIZE = 145,
   parameter int ADDR_W   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_byte,
   input  logic              in_last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              load_error,
   output logic [ADDR_W-1:0] byte_count,
   output logic [7:0]        checksum
);

   // Highest address the instruction memory can hold.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE,
      ERR
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [ADDR_W-1:0] r_nextAddr;
   logic              r_wrEn;
   logic [ADDR_W-1:0] r_wrAddr;
   logic [7:0]        r_wrData;
   logic              r_loadError;
   logic [ADDR_W-1:0] r_byteCount;
   logic [7:0]        r_checksum;

   logic              w_startOk;
   logic              w_startBad;
   logic              w_writeBeat;
   logic              w_overrun;

   // State register: the only place the FSM state changes. A synchronous
   // reset returns the loader to IDLE immediately, abandoning any load.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state decode. A start request is honoured from IDLE and from ERR
   // alike, so a failed load can be retried without a reset. In LOAD, each
   // transfer either becomes a memory write or, if the address has already
   // run past the end of memory, is swallowed and drives the FSM into ERR.
   always_comb begin
      w_stateNext = r_state;
      w_startOk   = 1'b0;
      w_startBad  = 1'b0;
      w_writeBeat = 1'b0;
      w_overrun   = 1'b0;
      case (r_state)
         IDLE, ERR: begin
            if (start) begin
               if (base_addr > LAST_ADDR) begin
                  w_startBad  = 1'b1;
                  w_stateNext = ERR;
               end else begin
                  w_startOk   = 1'b1;
                  w_stateNext = LOAD;
               end
            end
         end
         LOAD: begin
            if (in_valid) begin
               if (r_nextAddr <= LAST_ADDR) begin
                  w_writeBeat = 1'b1;
                  w_stateNext = in_last ? DONE : LOAD;
               end else begin
                  w_overrun   = 1'b1;
                  w_stateNext = ERR;
               end
            end
         end
         DONE: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Datapath registers. Every accepted in-range byte becomes a write pulse
   // in the following cycle, so the final write of a load coincides with the
   // single DONE cycle. The write address and data are left holding their
   // last values between pulses; only the strobe drops back to zero. Byte
   // count and checksum survive DONE and ERR so software can read them, and
   // are cleared only when a new load is actually accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_nextAddr  <= '0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
         r_loadError <= 1'b0;
         r_byteCount <= '0;
         r_checksum  <= '0;
      end else begin
         r_wrEn <= w_writeBeat;
         if (w_writeBeat) begin
            r_wrAddr    <= r_nextAddr;
            r_wrData    <= in_byte;
            r_nextAddr  <= r_nextAddr + ADDR_W'(1);
            r_byteCount <= r_byteCount + ADDR_W'(1);
            r_checksum  <= r_checksum ^ in_byte;
         end
         if (w_startOk) begin
            r_nextAddr  <= base_addr;
            r_byteCount <= '0;
            r_checksum  <= '0;
            r_loadError <= 1'b0;
         end
         if (w_startBad || w_overrun) begin
            r_loadError <= 1'b1;
         end
      end
   end

   // Handshake and status flags depend on the state alone, which keeps
   // in_ready free of any combinational path from the input stream.
   always_comb begin
      in_ready = (r_state == LOAD);
      busy     = (r_state == LOAD);
      cpu_hold = (r_state != IDLE);
      done     = (r_state == DONE);
   end

   assign wr_en      = r_wrEn;
   assign wr_addr    = r_wrAddr;
   assign wr_data    = r_wrData;
   assign load_error = r_loadError;
   assign byte_count = r_byteCount;
   assign checksum   = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: drives program byte streams and checks every
// memory write against a queue of expected (address, data) pairs, plus the
// status outputs at the points where they must change.
module tb_imem_loader;

   localparam int MEM_SIZE = 145;
   localparam int ADDR_W   = 64;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_byte;
   logic              in_last;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              load_error;
   logic [ADDR_W-1:0] byte_count;
   logic [7:0]        checksum;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   wr_t expQ[$];
   int  nCompared;
   int  nMismatched;

   imem_loader #(
      .MEM_SIZE(MEM_SIZE),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .in_last   (in_last),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .load_error(load_error),
      .byte_count(byte_count),
      .checksum  (checksum)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: every write pulse seen on the falling edge must match
   // the oldest expected write; a pulse with nothing expected is an error.
   always @(negedge clk) begin
      wr_t e;
      if (wr_en === 1'b1) begin
         nCompared++;
         if (expQ.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%02h, expected no write",
                     wr_addr, wr_data);
         end else begin
            e = expQ.pop_front();
            if (wr_addr !== e.addr || wr_data !== e.data) begin
               nMismatched++;
               $display("[TB] FAIL write: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                        wr_addr, wr_data, e.addr, e.data);
            end
         end
      end
   end

   // Drive one cycle of inputs (called at a falling edge) and return at the
   // next falling edge, after the DUT has seen them on the rising edge.
   task automatic applyStimulus(input logic s, input logic [ADDR_W-1:0] base,
                                input logic v, input logic [7:0] b, input logic l);
      start     = s;
      base_addr = base;
      in_valid  = v;
      in_byte   = b;
      in_last   = l;
      @(negedge clk);
   endtask

   task automatic pushWrite(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      expQ.push_back(e);
   endtask

   // Reset holds every output at zero.
   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);
      nCompared++;
      if ({in_ready, wr_en, cpu_hold, busy, done, load_error} !== 6'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_flags: got %b, expected 000000",
                  {in_ready, wr_en, cpu_hold, busy, done, load_error});
      end
      nCompared++;
      if (wr_addr !== '0 || wr_data !== 8'h00 || byte_count !== '0 || checksum !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL reset_data: got addr=%0d data=0x%02h count=%0d sum=0x%02h, expected all 0",
                  wr_addr, wr_data, byte_count, checksum);
      end
      reset = 1'b0;
   endtask

   // Three-byte load from address 0; done coincides with the last write.
   task automatic test_basic();
      applyStimulus(1, 0, 0, 8'h00, 0);
      nCompared++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL basic_load_state: got ready=%b busy=%b hold=%b, expected 1 1 1",
                  in_ready, busy, cpu_hold);
      end
      pushWrite(0, 8'h30);
      applyStimulus(0, 0, 1, 8'h30, 0);
      pushWrite(1, 8'hF2);
      applyStimulus(0, 0, 1, 8'hF2, 0);
      pushWrite(2, 8'h0A);
      applyStimulus(0, 0, 1, 8'h0A, 1);
      nCompared++;
      if (done !== 1'b1 || wr_en !== 1'b1 || cpu_hold !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL basic_done: got done=%b wr_en=%b hold=%b, expected 1 1 1",
                  done, wr_en, cpu_hold);
      end
      applyStimulus(0, 0, 0, 8'h00, 0);
      nCompared++;
      if (done !== 1'b0 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL basic_release: got done=%b hold=%b ready=%b, expected 0 0 0",
                  done, cpu_hold, in_ready);
      end
      nCompared++;
      if (byte_count !== 64'd3 || checksum !== 8'hC8) begin
         nMismatched++;
         $display("[TB] FAIL basic_totals: got count=%0d sum=0x%02h, expected count=3 sum=0xc8",
                  byte_count, checksum);
      end
      nCompared++;
      if (wr_addr !== 64'd2 || wr_data !== 8'h0A || wr_en !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL basic_hold: got addr=%0d data=0x%02h wr_en=%b, expected 2 0x0a 0",
                  wr_addr, wr_data, wr_en);
      end
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL basic_pending: got %0d writes outstanding, expected 0", expQ.size());
      end
   endtask

   // Gaps in in_valid produce no writes; addresses stay consecutive.
   task automatic test_backpressure();
      applyStimulus(1, 10, 0, 8'h00, 0);
      pushWrite(10, 8'h11);
      applyStimulus(0, 0, 1, 8'h11, 0);
      applyStimulus(0, 0, 0, 8'h99, 0);
      applyStimulus(0, 0, 0, 8'h99, 0);
      pushWrite(11, 8'h22);
      applyStimulus(0, 0, 1, 8'h22, 0);
      pushWrite(12, 8'h33);
      applyStimulus(0, 0, 1, 8'h33, 1);
      nCompared++;
      if (done !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL gap_done: got done=%b, expected 1", done);
      end
      applyStimulus(0, 0, 0, 8'h00, 0);
      nCompared++;
      if (byte_count !== 64'd3 || checksum !== 8'h00 || expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL gap_totals: got count=%0d sum=0x%02h pending=%0d, expected 3 0x00 0",
                  byte_count, checksum, expQ.size());
      end
   endtask

   // Load running off the end of memory: last two addresses written, then
   // the overflowing byte is dropped and the loader parks in ERR.
   task automatic test_boundary();
      applyStimulus(1, 143, 0, 8'h00, 0);
      pushWrite(143, 8'hAA);
      applyStimulus(0, 0, 1, 8'hAA, 0);
      pushWrite(144, 8'hBB);
      applyStimulus(0, 0, 1, 8'hBB, 0);
      applyStimulus(0, 0, 1, 8'hCC, 1);
      nCompared++;
      if (load_error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL boundary_err: got err=%b hold=%b ready=%b done=%b, expected 1 1 0 0",
                  load_error, cpu_hold, in_ready, done);
      end
      nCompared++;
      if (byte_count !== 64'd2 || checksum !== 8'h11) begin
         nMismatched++;
         $display("[TB] FAIL boundary_totals: got count=%0d sum=0x%02h, expected 2 0x11",
                  byte_count, checksum);
      end
      applyStimulus(0, 0, 1, 8'hDD, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);
      nCompared++;
      if (load_error !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0 || expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL boundary_sticky: got err=%b hold=%b busy=%b pending=%0d, expected 1 1 0 0",
                  load_error, cpu_hold, busy, expQ.size());
      end
   endtask

   // Out-of-range base address goes straight to ERR; a good one recovers.
   task automatic test_bad_base();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 8'h00, 0);
      reset = 1'b0;
      applyStimulus(1, 145, 0, 8'h00, 0);
      nCompared++;
      if (load_error !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL bad_base: got err=%b ready=%b hold=%b, expected 1 0 1",
                  load_error, in_ready, cpu_hold);
      end
      applyStimulus(1, 0, 0, 8'h00, 0);
      nCompared++;
      if (load_error !== 1'b0 || in_ready !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL bad_base_recover: got err=%b ready=%b, expected 0 1",
                  load_error, in_ready);
      end
   endtask

   // Reset in the middle of a load (entered in LOAD at address 0).
   task automatic test_reset_mid_load();
      pushWrite(0, 8'h01);
      applyStimulus(0, 0, 1, 8'h01, 0);
      pushWrite(1, 8'h02);
      applyStimulus(0, 0, 1, 8'h02, 0);
      reset = 1'b1;
      applyStimulus(0, 0, 1, 8'h03, 0);
      reset = 1'b0;
      nCompared++;
      if ({in_ready, wr_en, cpu_hold, busy, done, load_error} !== 6'b0 ||
          wr_addr !== '0 || wr_data !== 8'h00 || byte_count !== '0 || checksum !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL mid_reset: got flags=%b addr=%0d data=0x%02h count=%0d sum=0x%02h, expected all 0",
                  {in_ready, wr_en, cpu_hold, busy, done, load_error},
                  wr_addr, wr_data, byte_count, checksum);
      end
      applyStimulus(0, 0, 1, 8'h04, 0);
      applyStimulus(0, 0, 1, 8'h05, 1);
      applyStimulus(0, 0, 0, 8'h00, 0);
      nCompared++;
      if (in_ready !== 1'b0 || expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL mid_reset_quiet: got ready=%b pending=%0d, expected 0 0",
                  in_ready, expQ.size());
      end
   endtask

   // start during LOAD must not restart the address sequence.
   task automatic test_ignored_start();
      applyStimulus(1, 20, 0, 8'h00, 0);
      pushWrite(20, 8'h5A);
      applyStimulus(0, 0, 1, 8'h5A, 0);
      pushWrite(21, 8'h5B);
      applyStimulus(1, 50, 1, 8'h5B, 0);
      pushWrite(22, 8'h5C);
      applyStimulus(0, 0, 1, 8'h5C, 1);
      applyStimulus(0, 0, 0, 8'h00, 0);
      nCompared++;
      if (byte_count !== 64'd3 || checksum !== 8'h5D || expQ.size() != 0 || cpu_hold !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL ignored_start: got count=%0d sum=0x%02h pending=%0d hold=%b, expected 3 0x5d 0 0",
                  byte_count, checksum, expQ.size(), cpu_hold);
      end
   endtask

   // Test sequence.
   initial begin
      nCompared   = 0;
      nMismatched = 0;
      reset       = 1'b1;
      start       = 1'b0;
      base_addr   = '0;
      in_valid    = 1'b0;
      in_byte     = 8'h00;
      in_last     = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_boundary();
      test_bad_base();
      test_reset_mid_load();
      test_ignored_start();
      applyStimulus(0, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL final_pending: got %0d writes outstanding, expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
